// File: rtl/recip_sched.sv
// Shared reciprocal sequencer: round-robin arbitration between two requesters, then
// normalize / seed / Newton-Raphson / denormalize on one shared signed multiplier.
module recip_sched #(
    parameter int unsigned QM    = 10,
    parameter int unsigned QN    = 8,
    parameter int unsigned ITERS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [QM+QN-1:0] i_data_a,
    input  logic             i_valid_a,
    output logic             o_ready_a,
    input  logic [QM+QN-1:0] i_data_b,
    input  logic             i_valid_b,
    output logic             o_ready_b,
    output logic [QM+QN-1:0] o_result,
    output logic             o_sat,
    output logic             o_done_a,
    output logic             o_done_b,
    output logic             o_busy
);

    localparam int unsigned W      = QM + QN;
    localparam int unsigned NW     = $clog2(W + 1);
    localparam int unsigned F      = W + 2;       // fractional bits of y, t and m
    localparam int unsigned YW     = F + 2;       // y is unsigned in [0, 4)
    localparam int unsigned MW     = YW + 1;      // signed multiplier operand width
    localparam int unsigned PW     = 2 * MW;
    localparam int unsigned AW     = YW + W;
    localparam int unsigned SHW    = $clog2(AW + 1) + 1;
    // Right shift (minus one, for rounding) that turns y into the result at n = 0.
    localparam int unsigned SH_TOP = 2 * QM + 2 + W - 1;

    localparam logic [YW-1:0] SEED_C1   = YW'((48 << F) / 17);
    localparam logic [YW-1:0] SEED_C2   = YW'((32 << F) / 17);
    localparam logic [YW-1:0] Y_TWO     = YW'(2 << F);
    localparam logic [W-1:0]  MAX_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  ONE_W     = W'(1);
    localparam logic [2:0]    ITER_LAST = 3'(ITERS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StNorm,
        StSeed,
        StIterM,
        StIterC,
        StDenorm
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic [W-1:0]    op_q;
    logic            neg_q;
    logic            owner_q;
    logic [NW-1:0]   n_q;
    logic [W-1:0]    m_q;
    logic            zero_q;
    logic [YW-1:0]   y_q;
    logic [YW-1:0]   t_q;
    logic [2:0]      iter_q;

    logic [W-1:0]    mag;
    logic [NW-1:0]   lzc_cnt;
    logic [W-1:0]    m_norm;
    logic [YW-1:0]   m_ext;
    logic [YW-1:0]   mul_a, mul_b;
    logic signed [PW-1:0] mul_sa, mul_sb, prod;
    logic [YW-1:0]   prod_f;
    logic [YW-1:0]   y_seed;
    logic [AW-1:0]   acc, acc_sh, rnd;
    logic [SHW-1:0]  sh1;
    logic [W-1:0]    res_d;
    logic            sat_d;
    logic            unused_prod;

    lzc_b #(
        .SZ(W)
    ) u_lzc (
        .lzc_in (mag),
        .lzc_cnt(lzc_cnt)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // FSM: next state and round-robin pointer
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle:   if (o_ready_a || o_ready_b) state_d = StNorm;
            StNorm:   state_d = StSeed;
            StSeed:   state_d = StIterM;
            StIterM:  state_d = StIterC;
            StIterC:  state_d = (iter_q == ITER_LAST) ? StDenorm : StIterM;
            StDenorm: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (o_ready_a) begin
            rr_d = 1'b1;
        end else if (o_ready_b) begin
            rr_d = 1'b0;
        end
    end

    // FSM: outputs; a grant is withheld while reset is asserted so no handshake is lost
    always_comb begin
        o_ready_a = 1'b0;
        o_ready_b = 1'b0;
        o_busy    = (state_q != StIdle);
        if (state_q == StIdle && !reset) begin
            if (i_valid_a && (!i_valid_b || !rr_q)) begin
                o_ready_a = 1'b1;
            end else if (i_valid_b) begin
                o_ready_b = 1'b1;
            end
        end
    end

    always_comb begin
        mag    = op_q[W-1] ? (~op_q + ONE_W) : op_q;
        m_norm = mag << lzc_cnt;
        m_ext  = {2'b00, m_q, 2'b00};

        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StSeed: begin
                mul_a = SEED_C2;
                mul_b = m_ext;
            end
            StIterM: begin
                mul_a = m_ext;
                mul_b = y_q;
            end
            StIterC: begin
                mul_a = y_q;
                mul_b = Y_TWO - t_q;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        mul_sa      = $signed({{(PW-YW){1'b0}}, mul_a});
        mul_sb      = $signed({{(PW-YW){1'b0}}, mul_b});
        prod        = mul_sa * mul_sb;
        prod_f      = prod[F+YW-1:F];
        unused_prod = ^{prod[PW-1:F+YW], prod[F-1:0]};
        y_seed      = SEED_C1 - prod_f;
    end

    // Denormalize: r = y * 2^(n + 2*QN - W), rounded half-up on the magnitude
    always_comb begin
        acc    = {y_q, {W{1'b0}}};
        sh1    = SHW'(SH_TOP) - SHW'(n_q);
        acc_sh = acc >> sh1;
        rnd    = (acc_sh + AW'(1)) >> 1;
        sat_d  = 1'b0;
        if (zero_q) begin
            res_d = MAX_POS;
            sat_d = 1'b1;
        end else if (rnd > {{(AW-W){1'b0}}, MAX_POS}) begin
            res_d = neg_q ? (~MAX_POS + ONE_W) : MAX_POS;
            sat_d = 1'b1;
        end else begin
            res_d = neg_q ? (~rnd[W-1:0] + ONE_W) : rnd[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            owner_q  <= 1'b0;
            n_q      <= '0;
            m_q      <= '0;
            zero_q   <= 1'b0;
            y_q      <= '0;
            t_q      <= '0;
            iter_q   <= '0;
            o_result <= '0;
            o_sat    <= 1'b0;
            o_done_a <= 1'b0;
            o_done_b <= 1'b0;
        end else begin
            o_done_a <= 1'b0;
            o_done_b <= 1'b0;
            if (o_ready_a) begin
                op_q    <= i_data_a;
                neg_q   <= i_data_a[W-1];
                owner_q <= 1'b0;
            end else if (o_ready_b) begin
                op_q    <= i_data_b;
                neg_q   <= i_data_b[W-1];
                owner_q <= 1'b1;
            end
            unique case (state_q)
                StNorm: begin
                    n_q    <= lzc_cnt;
                    m_q    <= m_norm;
                    zero_q <= (mag == '0);
                end
                StSeed: begin
                    y_q    <= y_seed;
                    iter_q <= '0;
                end
                StIterM: t_q <= prod_f;
                StIterC: begin
                    y_q    <= prod_f;
                    iter_q <= iter_q + 3'd1;
                end
                StDenorm: begin
                    o_result <= res_d;
                    o_sat    <= sat_d;
                    o_done_a <= !owner_q;
                    o_done_b <= owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// Leading-zero counter; returns SZ for an all-zero input.
module lzc_b #(
    parameter int unsigned SZ = 18
) (
    input  logic [SZ-1:0]         lzc_in,
    output logic [$clog2(SZ+1)-1:0] lzc_cnt
);

    localparam int unsigned CW = $clog2(SZ + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lzc_cnt = CW'(SZ);
        for (int i = 0; i < SZ; i++) begin
            if (lzc_in[i]) lzc_cnt = CW'(SZ - 1 - i);
        end
    end

endmodule

// File: tb/tb_recip_sched.sv
// Testbench for recip_sched: directed and randomized operands checked against a real-valued
// 1/x model, plus arbitration, back-to-back and reset-abort scenarios.
module tb_recip_sched;

    localparam int QM    = 10;
    localparam int QN    = 8;
    localparam int W     = QM + QN;
    localparam int ITERS = 3;
    localparam int LAT   = 4 + 2 * ITERS;
    localparam logic [W-1:0] MAXV = 18'h1FFFF;
    localparam logic [W-1:0] NEGV = 18'h20001;

    logic         clk;
    logic         reset;
    logic [W-1:0] i_data_a, i_data_b;
    logic         i_valid_a, i_valid_b;
    logic         o_ready_a, o_ready_b;
    logic [W-1:0] o_result;
    logic         o_sat, o_done_a, o_done_b, o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    recip_sched #(
        .QM   (QM),
        .QN   (QN),
        .ITERS(ITERS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_data_a (i_data_a),
        .i_valid_a(i_valid_a),
        .o_ready_a(o_ready_a),
        .i_data_b (i_data_b),
        .i_valid_b(i_valid_b),
        .o_ready_b(o_ready_b),
        .o_result (o_result),
        .o_sat    (o_sat),
        .o_done_a (o_done_a),
        .o_done_b (o_done_b),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: exact 1/x in result LSB units, plus saturation expectation.
    function automatic void model(input logic [W-1:0] x, output bit sat, output logic [W-1:0] clamp,
                                  output real e);
        if (x == '0) begin
            sat   = 1'b1;
            clamp = MAXV;
            e     = 0.0;
        end else begin
            e     = $itor(1 << (2 * QN)) / $itor($signed(x));
            sat   = (e > 131071.5) || (e < -131071.5);
            clamp = (e > 0.0) ? MAXV : NEGV;
        end
    endfunction

    task automatic apply_reset();
        reset     = 1'b1;
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        i_data_a  = '0;
        i_data_b  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts at a negedge; runs one operation and reports what came back.
    task automatic do_op(input bit use_b, input logic [W-1:0] x, output logic [W-1:0] res,
                         output bit sat, output int lat, output bit da, output bit db,
                         output bit granted);
        if (use_b) begin
            i_data_b  = x;
            i_valid_b = 1'b1;
        end else begin
            i_data_a  = x;
            i_valid_a = 1'b1;
        end
        #1;
        granted = use_b ? o_ready_b : o_ready_a;
        @(negedge clk);
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        i_data_a  = W'($urandom);
        i_data_b  = W'($urandom);
        lat = 1;
        while (lat < 30 && !(o_done_a || o_done_b)) begin
            @(negedge clk);
            lat++;
        end
        res = o_result;
        sat = o_sat;
        da  = o_done_a;
        db  = o_done_b;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if ({o_result, o_sat, o_done_a, o_done_b, o_busy, o_ready_a, o_ready_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got res=%h sat=%b da=%b db=%b busy=%b ra=%b rb=%b, want 0",
                     o_result, o_sat, o_done_a, o_done_b, o_busy, o_ready_a, o_ready_b);
        end
        i_valid_a = 1'b1;
        i_valid_b = 1'b1;
        #1;
        n_tests++;
        if ({o_ready_a, o_ready_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_rr: got ready a/b=%b%b, want 10", o_ready_a, o_ready_b);
        end
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] vals[8] = '{18'h00100, 18'h00200, 18'h3FC00, 18'h00000,
                                  18'h00001, 18'h20000, 18'h1FFFF, 18'h3FFFF};
        logic [W-1:0] res, clamp;
        bit sat, da, db, gr, esat, use_b;
        int lat;
        real e, d;
        for (int i = 0; i < 8; i++) begin
            use_b = (i % 3 == 2);
            do_op(use_b, vals[i], res, sat, lat, da, db, gr);
            model(vals[i], esat, clamp, e);
            n_tests++;
            if (gr !== 1'b1 || lat != LAT || da !== !use_b || db !== use_b) begin
                n_fail++;
                $display("FAIL dir_handshake x=%h: got grant=%b lat=%0d da=%b db=%b, want 1 %0d %b %b",
                         vals[i], gr, lat, da, db, LAT, !use_b, use_b);
            end
            n_tests++;
            if (sat !== esat) begin
                n_fail++;
                $display("FAIL dir_sat x=%h: got %b, want %b", vals[i], sat, esat);
            end
            d = $itor($signed(res)) - e;
            if (d < 0.0) d = -d;
            n_tests++;
            if (esat ? (res !== clamp) : (d > 2.0)) begin
                n_fail++;
                $display("FAIL dir_value x=%h: got %h, want %f (+-2) or clamp %h",
                         vals[i], res, e, clamp);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, res, clamp;
        bit sat, da, db, gr, esat, use_b;
        int lat;
        int unsigned mag;
        real e, d;
        for (int i = 0; i < 30; i++) begin
            mag = $urandom_range(0, 131071) >> $urandom_range(0, 16);
            if ($urandom_range(0, 9) == 0) mag = 0;
            x = mag[W-1:0];
            if ($urandom_range(0, 1) == 1) x = ~x + 18'd1;
            use_b = ($urandom_range(0, 1) == 1);
            do_op(use_b, x, res, sat, lat, da, db, gr);
            model(x, esat, clamp, e);
            n_tests++;
            if (gr !== 1'b1 || lat != LAT || da !== !use_b || db !== use_b) begin
                n_fail++;
                $display("FAIL rnd_handshake x=%h: got grant=%b lat=%0d da=%b db=%b, want 1 %0d %b %b",
                         x, gr, lat, da, db, LAT, !use_b, use_b);
            end
            d = $itor($signed(res)) - e;
            if (d < 0.0) d = -d;
            n_tests++;
            if (sat !== esat || (esat ? (res !== clamp) : (d > 2.0))) begin
                n_fail++;
                $display("FAIL rnd_value x=%h: got %h sat=%b, want %f (+-2) sat=%b", x, res, sat,
                         e, esat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int g_who[$], g_cyc[$], d_who[$], d_cyc[$];
        logic [W-1:0] d_res[$];
        logic [W-1:0] clamp;
        bit esat;
        real ea, eb, e, d;
        model(18'h00100, esat, clamp, ea);
        model(18'h3FC00, esat, clamp, eb);
        reset     = 1'b1;
        i_data_a  = 18'h00100;
        i_data_b  = 18'h3FC00;
        i_valid_a = 1'b1;
        i_valid_b = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 42; c++) begin
            #1;
            if (o_ready_a) begin g_who.push_back(0); g_cyc.push_back(c); end
            if (o_ready_b) begin g_who.push_back(1); g_cyc.push_back(c); end
            if (o_done_a) begin d_who.push_back(0); d_cyc.push_back(c); d_res.push_back(o_result); end
            if (o_done_b) begin d_who.push_back(1); d_cyc.push_back(c); d_res.push_back(o_result); end
            if (o_done_a && o_done_b) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b_dual_done: both done pulses high at cycle %0d", c);
            end
            @(negedge clk);
        end
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (g_who.size() < 4 || d_who.size() < 4) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d grants %0d dones, want >=4 each", g_who.size(),
                     d_who.size());
        end
        for (int i = 0; i < 4 && i < g_who.size(); i++) begin
            n_tests++;
            if (g_who[i] != i % 2 || g_cyc[i] != i * LAT) begin
                n_fail++;
                $display("FAIL b2b_grant %0d: got who=%0d cyc=%0d, want who=%0d cyc=%0d", i,
                         g_who[i], g_cyc[i], i % 2, i * LAT);
            end
        end
        for (int i = 0; i < 4 && i < d_who.size(); i++) begin
            e = (i % 2 == 0) ? ea : eb;
            d = $itor($signed(d_res[i])) - e;
            if (d < 0.0) d = -d;
            n_tests++;
            if (d_who[i] != i % 2 || d_cyc[i] != (i + 1) * LAT || d > 2.0) begin
                n_fail++;
                $display("FAIL b2b_done %0d: got who=%0d cyc=%0d res=%h, want who=%0d cyc=%0d res=%f",
                         i, d_who[i], d_cyc[i], d_res[i], i % 2, (i + 1) * LAT, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] res, clamp;
        bit sat, da, db, gr, esat, seen;
        int lat;
        real e, d;
        i_data_a  = 18'h00100;
        i_valid_a = 1'b1;
        @(negedge clk);
        i_valid_a = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: got busy=%b in cycle 5, want 1", o_busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({o_result, o_sat, o_done_a, o_done_b, o_busy, o_ready_a, o_ready_b} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got res=%h sat=%b da=%b db=%b busy=%b, want 0",
                     o_result, o_sat, o_done_a, o_done_b, o_busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_done_a || o_done_b) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got a done pulse after reset, want none");
        end
        do_op(1'b0, 18'h00300, res, sat, lat, da, db, gr);
        model(18'h00300, esat, clamp, e);
        d = $itor($signed(res)) - e;
        if (d < 0.0) d = -d;
        n_tests++;
        if (gr !== 1'b1 || lat != LAT || da !== 1'b1 || sat !== 1'b0 || d > 2.0) begin
            n_fail++;
            $display("FAIL abort_fresh: got grant=%b lat=%0d da=%b sat=%b res=%h, want 1 %0d 1 0 %f",
                     gr, lat, da, sat, res, LAT, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        i_data_a  = '0;
        i_data_b  = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/recip_sched.md
# recip_sched

Shared reciprocal sequencer for the raycaster datapath. It arbitrates between two requesters, A and B, which are the rayDirX and rayDirY reciprocal consumers, and serves them round-robin. For each accepted operand it sequences one leading-zero counter (instance of `lzc_b`, WIDTH = QM+QN) and one shared signed multiplier through normalize, seed, Newton-Raphson and denormalize steps, then returns a signed fixed-point 1/x.

## Interface
Parameters:
- `QM`, default 10: integer bits of the signed Q format, sign included.
- `QN`, default 8: fractional bits. The operand and result width W = QM+QN must equal the `lzc_b` `SZ` (18).
- `ITERS`, default 3: number of Newton-Raphson iterations, range 1..4.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `i_data_a`, in, W: signed Q(QM.QN) operand from requester A.
- `i_valid_a`, in, 1: A has an operand pending.
- `o_ready_a`, out, 1: A's operand is accepted this cycle.
- `i_data_b`, in, W: operand from requester B.
- `i_valid_b`, in, 1: B has an operand pending.
- `o_ready_b`, out, 1: B's operand is accepted this cycle.
- `o_result`, out, W: signed Q(QM.QN) 1/x. Shared by both requesters and held until the next done pulse.
- `o_sat`, out, 1: result saturated. Qualified by a done pulse.
- `o_done_a`, out, 1: one-cycle pulse; `o_result` belongs to A.
- `o_done_b`, out, 1: one-cycle pulse; `o_result` belongs to B.
- `o_busy`, out, 1: high whenever state ≠ IDLE.

## Operation
States and transitions:
- IDLE → NORM on a handshake.
- NORM → SEED.
- SEED → ITER_M.
- ITER_M → ITER_C.
- ITER_C → ITER_M while the iteration count < ITERS, otherwise → DENORM.
- DENORM → IDLE.

Arbitration:
- Handshakes happen only in IDLE. `o_ready_a/b` are combinational from state, the valids and the round-robin pointer `rr`.
- If exactly one valid is high, that requester gets ready.
- If both are high, the requester selected by `rr` gets ready.
- At most one ready is high in any cycle.
- `rr` resets to A. After a grant it points at the other requester. `rr` does not change while no grant occurs.
- On a handshake, the operand, its sign and the owner ID are registered.

Datapath per step:
- NORM: register mag = |x| as W-bit unsigned (the most negative operand gives 2^(W-1)), n = `lzc_cnt`(mag), m = mag << n. The MSB of m is set unless mag = 0.
- SEED: y0 = 48/17 − 32/17·m, where m is read as 0.W in [0.5, 1). Internal precision is W+2 fractional bits.
- ITER_M: t = m·y (multiplier, cycle 1).
- ITER_C: y = y·(2 − t) (multiplier, cycle 2).
- DENORM: r = y·2^(n + 2·QN − W). Round to nearest, then apply the sign.

Saturation:
- Zero operand: `o_result` = +max (2^(W-1) − 1) and `o_sat` = 1.
- |r| above the max magnitude: result clamps to ±max and `o_sat` = 1.
- Otherwise `o_sat` = 0.

Accuracy: a non-saturated result is within ±2 LSB of the exact 1/x.

Reset:
- All outputs reset to 0, `rr` = A, state = IDLE.
- Reset during an operation aborts it. No done pulse is produced, and the operand is lost; the requester must resubmit.

## Timing
- Handshake in cycle 0 → NORM in cycle 1, SEED in cycle 2, ITER in cycles 3..2+2·ITERS, DENORM in cycle 3+2·ITERS.
- `o_result`, `o_sat` and the owner's done pulse are registered. They are asserted in cycle 4+2·ITERS, which is 10 cycles at the default ITERS.
- The done cycle is already IDLE, so a new handshake may coincide with a done pulse. Peak throughput is one op per 4+2·ITERS cycles.
- A valid held while the block is busy is accepted in the first IDLE cycle, subject to `rr`.
- Operand inputs are sampled only at the handshake. Changes after that are ignored.
- `o_done_a` and `o_done_b` are never high together.

## Test plan
- A = 0x00100 (1.0), B idle → `o_ready_a` in cycle 0; `o_done_a` in cycle 10 with `o_result` = 0x00100 ±2, `o_sat` = 0.
- A = 0x00200 (2.0), then B = 0x3FC00 (−4.0) → results 0x00080 (0.5) and 0x3FFC0 (−0.25), each ±2 LSB.
- A = 0 → `o_result` = 0x1FFFF, `o_sat` = 1. Also 1-LSB operand 0x00001 → 0x10000 (256.0) ±2, `o_sat` = 0.
- A and B held valid continuously from reset → grants alternate A, B, A, B. Handshakes are 10 cycles apart, and dones alternate `o_done_a`, `o_done_b`.
- Assert `reset` in cycle 5 of an A operation → no done pulse; all outputs are 0 the next cycle; a fresh request completes normally.
- Most negative operand 0x20000 (−512) → result 0x00000 or 0x3FFFF (±2 LSB of −1/512), `o_sat` = 0.
